cnn_window_feeder: RTL and testbench
====================================

Name: cnn_window_feeder

Overview:
- Streaming producer of 3x3 neighbourhoods for the CNN cell datapath. Accepts a row-major raster of cell outputs Y (2*WIDTH bits) and inputs U (WIDTH bits), one pixel per handshake.
- Emits one registered window per cell: Y1..Y9 and U1..U9 in row-major order, Y1 top-left, Y5 centre. Zero padding applies outside the image (fixed boundary).
- Sits in front of the per-cell A/B template multiply-accumulate and state-update logic.

Parameters:
- WIDTH, 9, template/input width; Y and X samples are 2*WIDTH bits signed.
- IMG_W, 16, image width in cells (>=3).
- IMG_H, 16, image height in cells (>=3).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  feeder can accept a pixel.
- in_y  in  2*WIDTH  signed Y sample for the next raster position.
- in_u  in  WIDTH  signed U sample for the same position.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer accepts the window.
- out_y  out  9*2*WIDTH  packed Y1..Y9; Yk occupies bits [k*2*WIDTH-1 -: 2*WIDTH].
- out_u  out  9*WIDTH  packed U1..U9, same packing rule.
- out_last  out  1  high with the window whose centre is (IMG_H-1, IMG_W-1).
- frame_done  out  1  one-cycle pulse after the out_last window is accepted.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - out_valid=0, out_y=0, out_u=0, out_last=0, frame_done=0.
  - All counters and the shift register cleared; state=FILL; the partial frame is discarded.
- Storage: one shift register of depth D=2*IMG_W+3 carrying {y,u}. Tap t holds the pixel accepted t shifts ago.
- Tap map:
  - Y9/U9=tap0, Y8=tap1, Y7=tap2
  - Y6=tap IMG_W, Y5=tap IMG_W+1, Y4=tap IMG_W+2
  - Y3=tap 2*IMG_W, Y2=tap 2*IMG_W+1, Y1=tap 2*IMG_W+2
- Handshakes: an input transfer occurs on in_valid&&in_ready; an output transfer on out_valid&&out_ready. out_y, out_u and out_last hold stable while out_valid&&!out_ready.
- States:
  - FILL: in_ready=1. Each transfer shifts in the pixel and produces no output. After IMG_W+1 transfers, go to RUN.
  - RUN: in_ready = !out_valid || out_ready.
    - Each input transfer shifts, then loads the output register on the same edge, so out_valid rises the cycle after the transfer (latency 1).
    - Input and output transfers in the same cycle are both honoured; sustained throughput is 1 window/cycle.
    - After input transfer number IMG_W*IMG_H, go to DRAIN.
  - DRAIN: in_ready=0. Whenever !out_valid || out_ready, shift in zero and load one window. After IMG_W+1 drain windows, go to DONE_WAIT.
  - DONE_WAIT: wait for the out_last transfer, pulse frame_done on the next cycle, then return to FILL with counters zeroed.
- Centre counters (row r, col c) advance per loaded window; c wraps at IMG_W-1 and increments r.
- Masking, applied at load time (needed because the shift register wraps across rows):
  - r==0 zeroes taps 1-3.
  - r==IMG_H-1 zeroes taps 7-9.
  - c==0 zeroes taps 1,4,7.
  - c==IMG_W-1 zeroes taps 3,6,9.
  - Corners combine both masks.
- Arithmetic: pure data movement. No sign change, truncation or extension; zero pads are signed zero.
- in_valid while in_ready=0 is ignored and has no side effect.

Decomposition:
- Shared package cnn_pkg:
  - WIDTH constant.
  - Y sample type (2*WIDTH signed) and U sample type (WIDTH signed).
  - Tap index functions tap_of(k, IMG_W) for k=1..9.
  - State enum {FILL, RUN, DRAIN, DONE_WAIT}.
- One sub-module: cnn_tap_shift (parameterised depth/width shift register with enable and all-tap output), instantiated once on the concatenated {y,u}.

Test Plan:
- Basic ramp: IMG_W=IMG_H=4, in_y=index+1, in_u=-(index+1), out_ready=1.
  - First window: Y1..Y4=0, Y5=1, Y6=2, Y7=0, Y8=5, Y9=6; U is the negation.
  - Centre (1,1) window: Y=1,2,3,5,6,7,9,10,11.
  - Last window: Y=11,12,0,15,16,0,0,0,0 with out_last=1.
  - Exactly 16 windows, then a frame_done pulse.
- Backpressure: hold out_ready=0 for 5 cycles mid-RUN -> out_y stable, in_ready=0, no pixel lost; the window sequence is identical to the ramp case.
- Random in_valid and out_ready gaps (50%) over 3 back-to-back frames, IMG_W=5, IMG_H=3 -> windows match a reference model; 15 windows per frame; frame_done count=3.
- Reset asserted after 9 input transfers -> outputs zero immediately (asynchronous). The next full frame produces the correct first window (Y5=1).
- Signed extremes: in_y=-131072 (0x20000), in_u=-256 everywhere -> interior windows carry exact values; pads are 0.
- DRAIN with out_ready toggling every cycle -> IMG_W+1 drain windows; in_ready stays 0 until back in FILL.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared types, constants and tap helpers for the CNN cell datapath.
package cnn_pkg;

    localparam int unsigned WIDTH = 9;
    localparam int unsigned YW    = 2 * WIDTH;
    localparam int unsigned UW    = WIDTH;

    typedef logic signed [YW-1:0] y_t;
    typedef logic signed [UW-1:0] u_t;

    // One raster pixel as carried through the neighbourhood shift register.
    typedef struct packed {
        y_t y;
        u_t u;
    } pixel_t;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DRAIN,
        DONE_WAIT
    } state_t;

    // Shift-register tap feeding window position k (1..9, row-major, 1 = top-left).
    function automatic int unsigned tap_of(input int unsigned k, input int unsigned img_w);
        int unsigned row;
        int unsigned col;
        row = (k - 1) / 3;
        col = (k - 1) % 3;
        return (2 - row) * img_w + (2 - col);
    endfunction

endpackage

// File: rtl/cnn_tap_shift.sv
// Enabled shift register exposing every tap; tap 0 is the most recent entry.
module cnn_tap_shift #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [DW-1:0]       din,
    output logic [DEPTH*DW-1:0] taps
);

    // Shift one entry towards the older taps on each enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (en) begin
            taps <= {taps[(DEPTH-1)*DW-1:0], din};
        end
    end

endmodule

// File: rtl/cnn_window_feeder.sv
// Streams zero-padded 3x3 Y/U neighbourhoods, one per cell, from a row-major raster.
module cnn_window_feeder
    import cnn_pkg::*;
#(
    parameter int unsigned IMG_W = 16,
    parameter int unsigned IMG_H = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  y_t              in_y,
    input  u_t              in_u,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [9*YW-1:0] out_y,
    output logic [9*UW-1:0] out_u,
    output logic            out_last,
    output logic            frame_done
);

    localparam int unsigned DEPTH = 2 * IMG_W + 3;
    localparam int unsigned PW    = YW + UW;
    localparam int unsigned NPIX  = IMG_W * IMG_H;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned DRN_W = $clog2(IMG_W + 2);
    localparam int unsigned ROW_W = $clog2(IMG_H);
    localparam int unsigned COL_W = $clog2(IMG_W);

    state_t             state;
    logic [CNT_W-1:0]   in_cnt;
    logic [DRN_W-1:0]   drain_cnt;
    logic [ROW_W-1:0]   row;
    logic [COL_W-1:0]   col;

    logic               in_fire;
    logic               out_fire;
    logic               drain_load;
    logic               load;
    logic               shift_en;
    pixel_t             shift_din;
    logic [DEPTH*PW-1:0] taps;
    logic               unused_taps;
    logic               at_top;
    logic               at_bot;
    logic               at_left;
    logic               at_right;
    logic [9*YW-1:0]    win_y;
    logic [9*UW-1:0]    win_u;

    // Input acceptance: free in FILL, gated by output slot in RUN, closed otherwise.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            FILL:    in_ready = 1'b1;
            RUN:     in_ready = !out_valid || out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign in_fire    = in_valid && in_ready;
    assign out_fire   = out_valid && out_ready;
    assign drain_load = (state == DRAIN) && (!out_valid || out_ready);
    assign load       = ((state == RUN) && in_fire) || drain_load;
    assign shift_en   = in_fire || drain_load;

    // Draining pushes zeros so the last rows reach the centre tap.
    always_comb begin
        shift_din = '0;
        if (!drain_load) begin
            shift_din.y = in_y;
            shift_din.u = in_u;
        end
    end

    cnn_tap_shift #(
        .DEPTH (DEPTH),
        .DW    (PW)
    ) u_shift (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (shift_en),
        .din   (shift_din),
        .taps  (taps)
    );

    // Only nine taps feed the window; the rest are pure delay.
    assign unused_taps = ^taps;

    assign at_top   = (row == '0);
    assign at_bot   = (row == ROW_W'(IMG_H - 1));
    assign at_left  = (col == '0);
    assign at_right = (col == COL_W'(IMG_W - 1));

    // Window built from the post-shift view so the load lands on the same edge as the shift.
    for (genvar k = 1; k <= 9; k++) begin : g_win
        localparam int unsigned TAP = tap_of(k, IMG_W);
        localparam bit KT = (k <= 3);
        localparam bit KB = (k >= 7);
        localparam bit KL = ((k - 1) % 3 == 0);
        localparam bit KR = ((k - 1) % 3 == 2);

        pixel_t src;
        logic   pad;

        if (TAP == 0) begin : g_new
            assign src = shift_din;
        end else begin : g_tap
            assign src = pixel_t'(taps[(TAP-1)*PW +: PW]);
        end

        assign pad = (KT && at_top) || (KB && at_bot) || (KL && at_left) || (KR && at_right);
        assign win_y[k*YW-1 -: YW] = pad ? '0 : src.y;
        assign win_u[k*UW-1 -: UW] = pad ? '0 : src.u;
    end

    // Frame sequencing, centre counters and the registered output window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FILL;
            in_cnt     <= '0;
            drain_cnt  <= '0;
            row        <= '0;
            col        <= '0;
            out_valid  <= 1'b0;
            out_y      <= '0;
            out_u      <= '0;
            out_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            if (load) begin
                out_valid <= 1'b1;
                out_y     <= win_y;
                out_u     <= win_u;
                out_last  <= at_bot && at_right;
                if (at_right) begin
                    col <= '0;
                    row <= at_bot ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end

            case (state)
                FILL: begin
                    if (in_fire) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == CNT_W'(IMG_W)) begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (in_fire) begin
                        in_cnt <= in_cnt + 1'b1;
                        if (in_cnt == CNT_W'(NPIX - 1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_load) begin
                        drain_cnt <= drain_cnt + 1'b1;
                        if (drain_cnt == DRN_W'(IMG_W)) begin
                            state <= DONE_WAIT;
                        end
                    end
                end
                DONE_WAIT: begin
                    if (out_fire && out_last) begin
                        frame_done <= 1'b1;
                        state      <= FILL;
                        in_cnt     <= '0;
                        drain_cnt  <= '0;
                        row        <= '0;
                        col        <= '0;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_window_feeder.sv
// Scoreboard bench for cnn_window_feeder on a 4x4 image.
module tb_cnn_window_feeder;
    import cnn_pkg::*;

    localparam int W = 4;
    localparam int H = 4;
    localparam int N = W * H;

    typedef struct {
        logic [9*YW-1:0] y;
        logic [9*UW-1:0] u;
        logic            last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_ready;
    y_t              in_y;
    u_t              in_u;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [9*YW-1:0] out_y;
    logic [9*UW-1:0] out_u;
    logic            out_last;
    logic            frame_done;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;
    int   win_cnt = 0;
    int   fd_cnt = 0;
    bit   sb_en = 0;
    int   mode = 0;
    int   cyc = 0;
    int   hold_end = 0;
    y_t   img_y [N];
    u_t   img_u [N];

    cnn_window_feeder #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .in_u       (in_u),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_u      (out_u),
        .out_last   (out_last),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input bit ok, input string name, input string detail);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // Consumer: always ready, random, toggling, or held off for a burst.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (cyc < hold_end) out_ready = 1'b0;
        else begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(1, 0));
                default: out_ready = !out_ready;
            endcase
        end
    end

    // Monitor: pops expected windows on output transfers, checks hold and frame_done timing.
    logic [9*YW-1:0] prev_y;
    logic [9*UW-1:0] prev_u;
    logic            prev_lst;
    bit              prev_stall = 0;
    bit              prev_last_acc = 0;
    always @(negedge clk) begin
        if (!sb_en || !rst_n) begin
            prev_stall    = 0;
            prev_last_acc = 0;
        end else begin
            check(frame_done == prev_last_acc, "frame_done_timing",
                  $sformatf("got %0b want %0b", frame_done, prev_last_acc));
            if (frame_done) fd_cnt++;
            if (prev_stall) begin
                check(out_valid && out_y == prev_y && out_u == prev_u && out_last == prev_lst,
                      "hold_stable", $sformatf("valid %0b y %h want %h", out_valid, out_y, prev_y));
            end
            if (out_valid && out_ready) begin
                win_cnt++;
                if (sbq.size() == 0) begin
                    check(1'b0, "unexpected_window", $sformatf("got y %h want none", out_y));
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    check(out_y == e.y, "win_y", $sformatf("got %h want %h", out_y, e.y));
                    check(out_u == e.u, "win_u", $sformatf("got %h want %h", out_u, e.u));
                    check(out_last == e.last, "win_last",
                          $sformatf("got %0b want %0b", out_last, e.last));
                end
            end
            prev_stall    = out_valid && !out_ready;
            prev_y        = out_y;
            prev_u        = out_u;
            prev_lst      = out_last;
            prev_last_acc = out_valid && out_ready && out_last;
        end
    end

    // Reference: each cell's 3x3 neighbourhood, zero outside the image.
    task automatic push_expected();
        for (int idx = 0; idx < N; idx++) begin
            exp_t e;
            int r;
            int c;
            r = idx / W;
            c = idx % W;
            e.y = '0;
            e.u = '0;
            for (int k = 0; k < 9; k++) begin
                int rr;
                int cc;
                rr = r + k / 3 - 1;
                cc = c + k % 3 - 1;
                if (rr >= 0 && rr < H && cc >= 0 && cc < W) begin
                    e.y[k*YW +: YW] = img_y[rr*W + cc];
                    e.u[k*UW +: UW] = img_u[rr*W + cc];
                end
            end
            e.last = (idx == N - 1);
            sbq.push_back(e);
        end
    endtask

    task automatic make_image(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0: begin img_y[i] = y_t'(i + 1); img_u[i] = u_t'(-(i + 1)); end
                1: begin img_y[i] = y_t'($urandom); img_u[i] = u_t'($urandom); end
                default: begin img_y[i] = y_t'(-131072); img_u[i] = u_t'(-256); end
            endcase
        end
    endtask

    task automatic send(input y_t y, input u_t u, input bit gaps);
        int n = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1) begin
                in_valid = 1'b0;
                @(posedge clk); #2;
            end
        end
        in_valid = 1'b1;
        in_y = y;
        in_u = u;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 2000);
        if (!in_ready) begin
            $display("FAIL send_timeout: in_ready still %0b after %0d cycles", in_ready, n);
            $fatal(1);
        end
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int kind, input bit gaps, input bit bp);
        int start_w;
        int start_fd;
        int n;
        make_image(kind);
        push_expected();
        start_w  = win_cnt;
        start_fd = fd_cnt;
        for (int i = 0; i < N; i++) begin
            if (bp && i == 7) hold_end = cyc + 6;
            send(img_y[i], img_u[i], gaps);
            if (bp && i == 7) begin
                check(!in_ready && out_valid, "bp_in_ready",
                      $sformatf("in_ready %0b out_valid %0b want 0 1", in_ready, out_valid));
            end
        end
        // Drain phase: offered junk must be refused until the frame completes.
        in_valid = 1'b1;
        in_y = y_t'(18'h15555);
        in_u = u_t'(9'h0aa);
        n = 0;
        while (!frame_done && n < 2000) begin
            check(!in_ready, "drain_in_ready", $sformatf("got %0b want 0", in_ready));
            @(posedge clk); #2;
            n++;
        end
        in_valid = 1'b0;
        check(n < 2000, "frame_done_timeout", $sformatf("waited %0d cycles want <2000", n));
        @(negedge clk); #1;
        check(win_cnt - start_w == N, "window_count",
              $sformatf("got %0d want %0d", win_cnt - start_w, N));
        check(fd_cnt - start_fd == 1, "frame_done_count",
              $sformatf("got %0d want 1", fd_cnt - start_fd));
        check(sbq.size() == 0, "scoreboard_empty", $sformatf("got %0d left want 0", sbq.size()));
        @(posedge clk); #2;
    endtask

    task automatic check_idle(input string tag);
        check(out_valid == 1'b0, {tag, "_valid"}, $sformatf("got %0b want 0", out_valid));
        check(out_y == '0, {tag, "_y"}, $sformatf("got %h want 0", out_y));
        check(out_u == '0, {tag, "_u"}, $sformatf("got %h want 0", out_u));
        check(out_last == 1'b0, {tag, "_last"}, $sformatf("got %0b want 0", out_last));
        check(frame_done == 1'b0, {tag, "_done"}, $sformatf("got %0b want 0", frame_done));
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_y     = '0;
        in_u     = '0;
        repeat (3) @(posedge clk);
        #2;
        check_idle("reset");
        check(in_ready == 1'b1, "reset_in_ready", $sformatf("got %0b want 1", in_ready));
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #2;
        sb_en = 1;

        mode = 0; run_frame(0, 0, 0);
        mode = 0; run_frame(0, 0, 1);
        mode = 1;
        repeat (3) run_frame(1, 1, 0);
        mode = 0; run_frame(2, 0, 0);

        // Asynchronous reset in the middle of a frame.
        sb_en = 0;
        make_image(0);
        for (int i = 0; i < 9; i++) send(img_y[i], img_u[i], 0);
        check(out_valid == 1'b1, "pre_reset_valid", $sformatf("got %0b want 1", out_valid));
        #1 rst_n = 1'b0;
        #1 check_idle("async_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        sbq.delete();
        @(posedge clk); #2;
        sb_en = 1;
        run_frame(0, 0, 0);

        mode = 2; run_frame(0, 0, 0);

        check(fd_cnt == 8, "total_frames", $sformatf("got %0d want 8", fd_cnt));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
